// File: rtl/tube_scan_ctrl.sv
// Scan driver for eight multiplexed 7-segment tubes: double-buffered image,
// frame-aligned commit, and a blanking gap ahead of every lit digit.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_BLANK | all tube outputs off for BLANK_CYCLES; cnt=0 at idx 0 = commit
//   S_ON    | digit idx driven for DIGIT_CYCLES, then idx advances mod 8
module tube_scan_ctrl #(
    parameter int DIGIT_CYCLES = 40000,
    parameter int BLANK_CYCLES = 400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [63:0] wr_seg,
    input  logic [7:0]  wr_mask,
    output logic        frame_done,
    output logic [7:0]  tube_l,
    output logic [7:0]  tube_r,
    output logic [7:0]  tube_en
);

    localparam int MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_CYCLES - 1);

    localparam logic S_BLANK = 1'b0;
    localparam logic S_ON    = 1'b1;

    logic          state, state_n;
    logic [2:0]    idx, idx_n;
    logic [CW-1:0] cnt, cnt_n;

    logic [63:0]   pend_seg;
    logic [7:0]    pend_mask;
    logic          pend_valid;
    logic [63:0]   active_seg, active_seg_n;
    logic [7:0]    active_mask, active_mask_n;

    logic          accept;
    logic          commit;
    logic          lit_n;
    logic [7:0]    byte_n;
    logic [7:0]    tube_en_n, tube_l_n, tube_r_n;
    logic          frame_done_n;

    assign wr_ready = ~pend_valid;
    assign accept   = wr_valid & ~pend_valid;
    assign commit   = (state == S_BLANK) && (idx == 3'd0) && (cnt == '0);

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt + CW'(1);
        if (state == S_BLANK) begin
            if (cnt == BLANK_LAST) begin
                state_n = S_ON;
                cnt_n   = '0;
            end
        end else begin
            if (cnt == DIGIT_LAST) begin
                state_n = S_BLANK;
                cnt_n   = '0;
                idx_n   = idx + 3'd1;
            end
        end
    end

    // Outputs are registered from next-cycle values so they line up with the
    // slot state of the same cycle rather than lagging by one.
    always_comb begin
        active_seg_n  = active_seg;
        active_mask_n = active_mask;
        if (commit && pend_valid) begin
            active_seg_n  = pend_seg;
            active_mask_n = pend_mask;
        end
        lit_n        = (state_n == S_ON) && active_mask_n[idx_n];
        byte_n       = active_seg_n[{idx_n, 3'b000} +: 8];
        tube_en_n    = lit_n ? (8'd1 << idx_n) : 8'd0;
        tube_l_n     = (lit_n && !idx_n[2]) ? byte_n : 8'd0;
        tube_r_n     = (lit_n &&  idx_n[2]) ? byte_n : 8'd0;
        frame_done_n = (state_n == S_ON) && (idx_n == 3'd7) && (cnt_n == DIGIT_LAST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_BLANK;
            idx         <= 3'd0;
            cnt         <= '0;
            pend_seg    <= '0;
            pend_mask   <= '0;
            pend_valid  <= 1'b0;
            active_seg  <= '0;
            active_mask <= '0;
            tube_en     <= '0;
            tube_l      <= '0;
            tube_r      <= '0;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            cnt         <= cnt_n;
            active_seg  <= active_seg_n;
            active_mask <= active_mask_n;
            if (accept) begin
                pend_seg  <= wr_seg;
                pend_mask <= wr_mask;
            end
            if (commit && pend_valid) begin
                pend_valid <= 1'b0;
            end else if (accept) begin
                pend_valid <= 1'b1;
            end
            tube_en    <= tube_en_n;
            tube_l     <= tube_l_n;
            tube_r     <= tube_r_n;
            frame_done <= frame_done_n;
        end
    end

endmodule

// File: doc/tube_scan_ctrl.md
Name: tube_scan_ctrl

Overview:
- Time-multiplexed driver for the board's eight 7-segment tubes: two segment buses (tube_l for digits 0-3, tube_r for digits 4-7) and one enable per digit.
- Sits between core and the tube pins. Core posts a full 8-digit image through a valid/ready handshake.
- The block double-buffers the image, commits it only at frame boundaries (no tearing) and inserts blanking between digits to suppress ghosting.

Parameters:
- DIGIT_CYCLES, 40000, clk cycles a digit is lit per slot (1 ms at 40 MHz); must be ≥1.
- BLANK_CYCLES, 400, clk cycles of all-off before each digit is lit; must be ≥1.

Ports:
- clk  input  1  pixel-domain clock.
- reset  input  1  asynchronous, active-low reset.
- wr_valid  input  1  core offers a new image.
- wr_ready  output  1  pending buffer empty; transfer when wr_valid & wr_ready.
- wr_seg  input  64  segment bytes; digit i = bits [8i+7:8i], bit=1 lights segment.
- wr_mask  input  8  per-digit enable; 0 keeps that digit dark.
- frame_done  output  1  one-cycle pulse on the last cycle of each frame.
- tube_l  output  8  segments for digits 0-3, active-high.
- tube_r  output  8  segments for digits 4-7, active-high.
- tube_en  output  8  digit enables, active-high, one-hot or zero.

Behaviour:
- Reset (asynchronous, while reset=0):
  - tube_l, tube_r, tube_en = 0; frame_done = 0; wr_ready = 1.
  - Active and pending buffers = 0; pending-valid = 0; slot state = BLANK, idx = 0, cnt = 0.
  - Reset asserted mid-frame or mid-handshake discards everything immediately.
- Slot FSM, states BLANK and ON; cnt counts cycles within the state:
  - BLANK: all outputs 0 for BLANK_CYCLES cycles, then go to ON with cnt = 0.
  - ON: drive digit idx for DIGIT_CYCLES cycles, then go to BLANK with idx = (idx+1) mod 8 (7 wraps to 0).
- Timing: slot period T = BLANK_CYCLES + DIGIT_CYCLES; frame = 8T. Frame k occupies cycles [8kT, 8(k+1)T), counted from the first edge after reset release.
- ON drive:
  - tube_en = 1<<idx if active_mask[idx], else 0.
  - If idx<4: tube_l = active_seg[idx], tube_r = 0. Otherwise tube_r = active_seg[idx], tube_l = 0.
  - If the mask bit is 0, both segment buses are also 0.
  - All tube outputs are registered and glitch-free; never two enables high at once.
- Handshake:
  - Transfer on wr_valid & wr_ready: wr_seg/wr_mask → pending, pending-valid = 1, wr_ready = 0 from the next cycle.
  - wr_data may change freely when no transfer occurs.
- Commit cycle = state BLANK, idx = 0, cnt = 0 (the first cycle of each frame):
  - If pending-valid, active ← pending, pending-valid ← 0, wr_ready = 1 next cycle.
  - That frame displays the committed image.
- Simultaneous events:
  - A transfer on a commit cycle is impossible while pending is full (wr_ready = 0).
  - If pending was empty, a transfer on a commit cycle lands in pending and commits one frame later.
- A second write while pending is full is not accepted (wr_ready = 0). Only the latest accepted image is ever committed; active is never written outside a commit cycle.
- frame_done = 1 exactly on the last cycle of ON for idx = 7; 0 otherwise. It never pulses during reset.
- Counters are sized by $clog2 of the max of the two parameters; no overflow is possible.

Test Plan (DIGIT_CYCLES=8, BLANK_CYCLES=2, T=10, frame=80):
- Reset then idle 200 cycles:
  - wr_ready = 1 throughout; tube_en = 0, tube_l = tube_r = 0 always.
  - frame_done pulses at cycles 79 and 159 only.
- Write wr_seg=64'h8877665544332211, wr_mask=8'hFF at cycle 5:
  - wr_ready = 0 from cycle 6; frame 0 stays dark.
  - At cycle 80 commit, wr_ready returns to 1.
  - Cycles 82-89: tube_en=8'h01, tube_l=8'h11, tube_r=0.
  - Cycles 122-129: tube_en=8'h10, tube_r=8'h55, tube_l=0.
  - Cycles 80-81 are all zero.
- wr_mask=8'hA5 image: in slots 1, 3, 4, 6 (mask bits clear) tube_en and both segment buses stay 0 for all 10 cycles. The other slots display normally.
- Hold wr_valid=1 with differing data on consecutive cycles while pending is full:
  - Only the first accepted image commits; wr_ready stays 0 until the commit cycle.
  - Check simultaneous wr_valid on cycle 160 with pending empty: the image appears from frame 3 (cycle 240), not frame 2.
- Assert reset=0 at cycle 125 (digit 4 lit):
  - All tube outputs go 0 asynchronously before the next edge; wr_ready = 1.
  - After release, the image is blank and the timeline restarts from cycle 0.
- Run 10 frames with random writes: tube_en is always zero or one-hot; a BLANK gap of exactly 2 cycles precedes every lit slot.
